// File: rtl/l2send_if.sv
// l2send_if: groups the l2 request handshake, the l2recv fill-done return
// and the shared-bus request/nack signals of the l2send transmitter.
//   master : l2send's view (drives ready/tag/upgr_done/bus_req_*)
//   slave  : the surrounding l2 / l2recv / bus view
interface l2send_if;
    logic        l2_l2send_valid;
    logic [2:0]  l2_l2send_cmd;
    logic [25:0] l2_l2send_addr;
    logic        l2send_l2_ready;
    logic [2:0]  l2send_l2_tag;
    logic        l2send_l2_upgr_done;
    logic [2:0]  l2send_l2_upgr_tag;
    logic        l2recv_l2send_done;
    logic [2:0]  l2recv_l2send_tag;
    logic        bus_req_valid;
    logic [2:0]  bus_req_cmd;
    logic [4:0]  bus_req_tag;
    logic [29:0] bus_req_addr;
    logic        bus_nack;

    modport master (
        input  l2_l2send_valid, l2_l2send_cmd, l2_l2send_addr,
        input  l2recv_l2send_done, l2recv_l2send_tag, bus_nack,
        output l2send_l2_ready, l2send_l2_tag,
        output l2send_l2_upgr_done, l2send_l2_upgr_tag,
        output bus_req_valid, bus_req_cmd, bus_req_tag, bus_req_addr
    );

    modport slave (
        output l2_l2send_valid, l2_l2send_cmd, l2_l2send_addr,
        output l2recv_l2send_done, l2recv_l2send_tag, bus_nack,
        input  l2send_l2_ready, l2send_l2_tag,
        input  l2send_l2_upgr_done, l2send_l2_upgr_tag,
        input  bus_req_valid, bus_req_cmd, bus_req_tag, bus_req_addr
    );
endinterface

// File: rtl/l2send.sv
// l2send: L2 bus transmitter. Accepts BUSRD/BUSRDX/BUSUPGR misses from l2,
// parks each in an 8-entry tag table, issues one request per TDM round in
// this node's slot, retries on nack, and frees tags when l2recv reports the
// fill (or, for BUSUPGR, as soon as the nack window passes cleanly).
// Ports:
//   clk  : clock
//   rst  : synchronous reset, active low
//   lnk  : l2send_if.master -- l2 request handshake, upgrade-done pulse,
//          l2recv fill-done, shared-bus request outputs and nack input
//
// Tag table entry states:
//   state        | meaning
//   ST_FREE      | entry unused, may be handed to l2
//   ST_ISSUE     | waiting for our slot to drive the bus
//   ST_NACKWAIT  | on the bus, waiting for the nack sample cycle
//   ST_OUTSTND   | accepted by the bus, waiting for l2recv fill-done
module l2send #(
    parameter logic [1:0] NODE_ID  = 2'd0,
    parameter logic [2:0] SLOT     = 3'd0,
    parameter int         NACK_LAT = 2
) (
    input logic      clk,
    input logic      rst,
    l2send_if.master lnk
);

    typedef enum logic [1:0] {
        ST_FREE,
        ST_ISSUE,
        ST_NACKWAIT,
        ST_OUTSTND
    } entry_state_t;

    localparam logic [2:0] CMD_BUSUPGR = 3'b011;
    // Bus outputs are registered, so the load happens one edge ahead of SLOT.
    localparam logic [2:0] ISSUE_CYC   = SLOT - 3'd1;
    localparam logic [2:0] NACK_CYC    = 3'((int'(SLOT) + NACK_LAT) % 8);

    entry_state_t st     [8];
    logic [2:0]   cmd_q  [8];
    logic [25:0]  addr_q [8];
    logic [2:0]   cyc_r;

    logic       any_free;
    logic       addr_hit;
    logic       any_issue;
    logic [2:0] free_idx;
    logic [2:0] issue_idx;
    logic       ready;
    logic       accept;

    // Descending scan leaves the lowest matching index in the result.
    always_comb begin
        any_free  = 1'b0;
        addr_hit  = 1'b0;
        any_issue = 1'b0;
        free_idx  = 3'd0;
        issue_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (st[i] == ST_FREE) begin
                any_free = 1'b1;
                free_idx = 3'(i);
            end else if (addr_q[i] == lnk.l2_l2send_addr) begin
                addr_hit = 1'b1;
            end
            if (st[i] == ST_ISSUE) begin
                any_issue = 1'b1;
                issue_idx = 3'(i);
            end
        end
    end

    // A second miss to a line already in flight is held off until that
    // line's tag is released.
    assign ready                = any_free & ~addr_hit;
    assign accept               = lnk.l2_l2send_valid & ready;
    assign lnk.l2send_l2_ready  = ready;
    assign lnk.l2send_l2_tag    = free_idx;

    // Accept, issue, nack resolution and done each touch an entry in a
    // different state, so they never collide on one index in a cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cyc_r                   <= 3'd0;
            lnk.bus_req_valid       <= 1'b0;
            lnk.bus_req_cmd         <= 3'd0;
            lnk.bus_req_tag         <= 5'd0;
            lnk.bus_req_addr        <= 30'd0;
            lnk.l2send_l2_upgr_done <= 1'b0;
            lnk.l2send_l2_upgr_tag  <= 3'd0;
            for (int i = 0; i < 8; i++) begin
                st[i]     <= ST_FREE;
                cmd_q[i]  <= 3'd0;
                addr_q[i] <= 26'd0;
            end
        end else begin
            cyc_r                   <= cyc_r + 3'd1;
            lnk.bus_req_valid       <= 1'b0;
            lnk.l2send_l2_upgr_done <= 1'b0;

            if (accept) begin
                st[free_idx]     <= ST_ISSUE;
                cmd_q[free_idx]  <= lnk.l2_l2send_cmd;
                addr_q[free_idx] <= lnk.l2_l2send_addr;
            end

            if (cyc_r == ISSUE_CYC && any_issue) begin
                st[issue_idx]     <= ST_NACKWAIT;
                lnk.bus_req_valid <= 1'b1;
                lnk.bus_req_cmd   <= cmd_q[issue_idx];
                lnk.bus_req_tag   <= {NODE_ID, issue_idx};
                lnk.bus_req_addr  <= {addr_q[issue_idx], 4'b0000};
            end

            if (cyc_r == NACK_CYC) begin
                for (int i = 0; i < 8; i++) begin
                    if (st[i] == ST_NACKWAIT) begin
                        if (lnk.bus_nack) begin
                            st[i] <= ST_ISSUE;
                        end else if (cmd_q[i] == CMD_BUSUPGR) begin
                            // An upgrade carries no data, so it is complete here.
                            st[i]                   <= ST_FREE;
                            lnk.l2send_l2_upgr_done <= 1'b1;
                            lnk.l2send_l2_upgr_tag  <= 3'(i);
                        end else begin
                            st[i] <= ST_OUTSTND;
                        end
                    end
                end
            end

            if (lnk.l2recv_l2send_done && st[lnk.l2recv_l2send_tag] == ST_OUTSTND) begin
                st[lnk.l2recv_l2send_tag] <= ST_FREE;
            end
        end
    end

endmodule

// File: tb/tb_l2send.sv
// tb_l2send: scoreboard bench for l2send (NODE_ID=2, SLOT=0, NACK_LAT=2).
// Expected bus requests are queued when l2 requests are accepted (or when a
// nack forces a retry) and popped when the DUT drives the bus.
module tb_l2send;
    localparam logic [1:0]  NODE_ID   = 2'd2;
    localparam logic [2:0]  SLOT      = 3'd0;
    localparam int          NACK_LAT  = 2;
    localparam logic [2:0]  C_RD      = 3'b001;
    localparam logic [2:0]  C_RDX     = 3'b010;
    localparam logic [2:0]  C_UPGR    = 3'b011;
    localparam logic [25:0] IDLE_ADDR = 26'h3FFFFFF;

    typedef struct packed {
        logic [2:0]  cmd;
        logic [4:0]  tag;
        logic [29:0] addr;
    } issue_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    l2send_if sif();

    l2send #(.NODE_ID(NODE_ID), .SLOT(SLOT), .NACK_LAT(NACK_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .lnk (sif)
    );

    always #5 clk = ~clk;

    logic [2:0] tcyc = 3'd0;
    int         ncyc = 0;
    always @(posedge clk) begin
        if (!rst) tcyc <= 3'd0;
        else      tcyc <= tcyc + 3'd1;
        ncyc <= ncyc + 1;
    end

    issue_t exp_q[$];
    issue_t got, exp;
    bit     found;
    int     checks = 0;
    int     errors = 0;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench timeout");
    end

    function automatic issue_t mk(input logic [2:0] cmd, input logic [2:0] idx,
                                  input logic [25:0] addr);
        return {cmd, NODE_ID, idx, addr, 4'b0000};
    endfunction

    task automatic idle_inputs();
        sif.l2_l2send_valid    = 1'b0;
        sif.l2_l2send_cmd      = 3'd0;
        sif.l2_l2send_addr     = IDLE_ADDR;
        sif.l2recv_l2send_done = 1'b0;
        sif.l2recv_l2send_tag  = 3'd0;
        sif.bus_nack           = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic goto_cyc(input logic [2:0] c);
        for (int k = 0; k < 9; k++) begin
            if (tcyc == c) break;
            @(negedge clk);
        end
    endtask

    task automatic present(input logic [2:0] cmd, input logic [25:0] addr);
        sif.l2_l2send_valid = 1'b1;
        sif.l2_l2send_cmd   = cmd;
        sif.l2_l2send_addr  = addr;
        #1;
    endtask

    task automatic release_req();
        sif.l2_l2send_valid = 1'b0;
        sif.l2_l2send_addr  = IDLE_ADDR;
    endtask

    task automatic pulse_done(input logic [2:0] tag);
        sif.l2recv_l2send_done = 1'b1;
        sif.l2recv_l2send_tag  = tag;
        @(negedge clk);
        sif.l2recv_l2send_done = 1'b0;
        #1;
    endtask

    task automatic wait_issue(output bit f);
        f = 1'b0;
        for (int k = 0; k < 24; k++) begin
            if (sif.bus_req_valid === 1'b1) begin
                f = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (sif.l2send_l2_ready !== 1'b1 || sif.l2send_l2_tag !== 3'd0) begin
            errors++;
            $display("FAIL reset_ready got ready=%b tag=%0d required ready=1 tag=0",
                     sif.l2send_l2_ready, sif.l2send_l2_tag);
        end
        checks++;
        if ({sif.bus_req_valid, sif.bus_req_cmd, sif.bus_req_tag, sif.bus_req_addr,
             sif.l2send_l2_upgr_done, sif.l2send_l2_upgr_tag} !== 43'd0) begin
            errors++;
            $display("FAIL reset_regs got valid=%b cmd=%h tag=%h addr=%h ud=%b ut=%0d required all 0",
                     sif.bus_req_valid, sif.bus_req_cmd, sif.bus_req_tag, sif.bus_req_addr,
                     sif.l2send_l2_upgr_done, sif.l2send_l2_upgr_tag);
        end
    endtask

    task automatic test_first_issue();
        goto_cyc(3);
        present(C_RD, 26'h12345);
        checks++;
        if (sif.l2send_l2_ready !== 1'b1 || sif.l2send_l2_tag !== 3'd0) begin
            errors++;
            $display("FAIL first_accept got ready=%b tag=%0d required ready=1 tag=0",
                     sif.l2send_l2_ready, sif.l2send_l2_tag);
        end
        exp_q.push_back(mk(C_RD, 3'd0, 26'h12345));
        @(negedge clk);
        release_req();
        wait_issue(found);
        checks++;
        if (!found || exp_q.size() == 0) begin
            errors++;
            $display("FAIL first_issue got found=%0b queued=%0d required an issue", found, exp_q.size());
        end else begin
            exp = exp_q.pop_front();
            got = {sif.bus_req_cmd, sif.bus_req_tag, sif.bus_req_addr};
            if (got !== exp || tcyc !== SLOT) begin
                errors++;
                $display("FAIL first_issue got %h at cyc %0d required %h at cyc %0d", got, tcyc, exp, SLOT);
            end
        end
        @(negedge clk);
        checks++;
        if (sif.bus_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL one_cycle_valid got %b required 0", sif.bus_req_valid);
        end
    endtask

    task automatic test_nack_retry();
        goto_cyc(2);
        sif.bus_nack = 1'b1;
        @(negedge clk);
        sif.bus_nack = 1'b0;
        exp_q.push_back(mk(C_RD, 3'd0, 26'h12345));
        wait_issue(found);
        checks++;
        if (!found || exp_q.size() == 0) begin
            errors++;
            $display("FAIL retry_issue got found=%0b queued=%0d required an issue", found, exp_q.size());
        end else begin
            exp = exp_q.pop_front();
            got = {sif.bus_req_cmd, sif.bus_req_tag, sif.bus_req_addr};
            if (got !== exp || tcyc !== SLOT) begin
                errors++;
                $display("FAIL retry_issue got %h at cyc %0d required %h at cyc %0d", got, tcyc, exp, SLOT);
            end
        end
        @(negedge clk);
        goto_cyc(3);
        checks++;
        if (sif.l2send_l2_ready !== 1'b1 || sif.l2send_l2_tag !== 3'd1) begin
            errors++;
            $display("FAIL outstnd_ready got ready=%b tag=%0d required ready=1 tag=1",
                     sif.l2send_l2_ready, sif.l2send_l2_tag);
        end
    endtask

    task automatic test_addr_block();
        present(C_RD, 26'h12345);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (sif.l2send_l2_ready !== 1'b0) begin
                errors++;
                $display("FAIL addr_block_%0d got ready=%b required 0", k, sif.l2send_l2_ready);
            end
            @(negedge clk);
            #1;
        end
        pulse_done(3'd0);
        checks++;
        if (sif.l2send_l2_ready !== 1'b1 || sif.l2send_l2_tag !== 3'd0) begin
            errors++;
            $display("FAIL addr_unblock got ready=%b tag=%0d required ready=1 tag=0",
                     sif.l2send_l2_ready, sif.l2send_l2_tag);
        end
        exp_q.push_back(mk(C_RD, 3'd0, 26'h12345));
        @(negedge clk);
        release_req();
        wait_issue(found);
        checks++;
        if (!found || exp_q.size() == 0) begin
            errors++;
            $display("FAIL reaccept_issue got found=%0b queued=%0d required an issue", found, exp_q.size());
        end else begin
            exp = exp_q.pop_front();
            got = {sif.bus_req_cmd, sif.bus_req_tag, sif.bus_req_addr};
            if (got !== exp || tcyc !== SLOT) begin
                errors++;
                $display("FAIL reaccept_issue got %h at cyc %0d required %h at cyc %0d", got, tcyc, exp, SLOT);
            end
        end
    endtask

    task automatic test_upgr();
        do_reset();
        goto_cyc(3);
        present(C_UPGR, 26'h00ABC);
        exp_q.push_back(mk(C_UPGR, 3'd0, 26'h00ABC));
        @(negedge clk);
        release_req();
        wait_issue(found);
        checks++;
        if (!found || exp_q.size() == 0) begin
            errors++;
            $display("FAIL upgr_issue got found=%0b queued=%0d required an issue", found, exp_q.size());
        end else begin
            exp = exp_q.pop_front();
            got = {sif.bus_req_cmd, sif.bus_req_tag, sif.bus_req_addr};
            if (got !== exp || tcyc !== SLOT) begin
                errors++;
                $display("FAIL upgr_issue got %h at cyc %0d required %h at cyc %0d", got, tcyc, exp, SLOT);
            end
        end
        // nack high on cycles 1 and 3 lies outside the window and must be ignored
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            sif.bus_nack = (c == 1 || c == 3);
            checks++;
            if (sif.l2send_l2_upgr_done !== (c == 3) ||
                (c == 3 && sif.l2send_l2_upgr_tag !== 3'd0)) begin
                errors++;
                $display("FAIL upgr_done_cyc%0d got done=%b tag=%0d required done=%0b tag=0",
                         c, sif.l2send_l2_upgr_done, sif.l2send_l2_upgr_tag, (c == 3));
            end
        end
        sif.bus_nack = 1'b0;
        pulse_done(3'd0);
        found = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (sif.bus_req_valid === 1'b1 || sif.l2send_l2_upgr_done === 1'b1) found = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (found || sif.l2send_l2_ready !== 1'b1 || sif.l2send_l2_tag !== 3'd0) begin
            errors++;
            $display("FAIL upgr_late_done got activity=%0b ready=%b tag=%0d required 0/1/0",
                     found, sif.l2send_l2_ready, sif.l2send_l2_tag);
        end
        // second upgrade lands on tag 1 behind a plain read on tag 0
        goto_cyc(3);
        present(C_RD, 26'h0C0DE);
        exp_q.push_back(mk(C_RD, 3'd0, 26'h0C0DE));
        @(negedge clk);
        present(C_UPGR, 26'h0BEEF);
        checks++;
        if (sif.l2send_l2_ready !== 1'b1 || sif.l2send_l2_tag !== 3'd1) begin
            errors++;
            $display("FAIL upgr2_accept got ready=%b tag=%0d required ready=1 tag=1",
                     sif.l2send_l2_ready, sif.l2send_l2_tag);
        end
        exp_q.push_back(mk(C_UPGR, 3'd1, 26'h0BEEF));
        @(negedge clk);
        release_req();
        for (int n = 0; n < 2; n++) begin
            wait_issue(found);
            checks++;
            if (!found || exp_q.size() == 0) begin
                errors++;
                $display("FAIL upgr2_issue%0d got found=%0b queued=%0d required an issue", n, found, exp_q.size());
            end else begin
                exp = exp_q.pop_front();
                got = {sif.bus_req_cmd, sif.bus_req_tag, sif.bus_req_addr};
                if (got !== exp || tcyc !== SLOT) begin
                    errors++;
                    $display("FAIL upgr2_issue%0d got %h at cyc %0d required %h at cyc %0d", n, got, tcyc, exp, SLOT);
                end
            end
            @(negedge clk);
        end
        goto_cyc(3);
        checks++;
        if (sif.l2send_l2_upgr_done !== 1'b1 || sif.l2send_l2_upgr_tag !== 3'd1) begin
            errors++;
            $display("FAIL upgr2_done got done=%b tag=%0d required done=1 tag=1",
                     sif.l2send_l2_upgr_done, sif.l2send_l2_upgr_tag);
        end
    endtask

    task automatic test_fill();
        int last;
        logic [25:0] a;
        last = 0;
        do_reset();
        goto_cyc(0);
        for (int i = 0; i < 8; i++) begin
            a = 26'h100 + 26'(i);
            present(C_RD, a);
            checks++;
            if (sif.l2send_l2_ready !== 1'b1 || sif.l2send_l2_tag !== 3'(i)) begin
                errors++;
                $display("FAIL fill_accept%0d got ready=%b tag=%0d required ready=1 tag=%0d",
                         i, sif.l2send_l2_ready, sif.l2send_l2_tag, i);
            end
            exp_q.push_back(mk(C_RD, 3'(i), a));
            @(negedge clk);
        end
        release_req();
        #1;
        checks++;
        if (sif.l2send_l2_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill_full got ready=%b required 0", sif.l2send_l2_ready);
        end
        for (int i = 0; i < 8; i++) begin
            wait_issue(found);
            checks++;
            if (!found || exp_q.size() == 0) begin
                errors++;
                $display("FAIL fill_issue%0d got found=%0b queued=%0d required an issue", i, found, exp_q.size());
            end else begin
                exp = exp_q.pop_front();
                got = {sif.bus_req_cmd, sif.bus_req_tag, sif.bus_req_addr};
                if (got !== exp || tcyc !== SLOT || (i > 0 && ncyc - last != 8)) begin
                    errors++;
                    $display("FAIL fill_issue%0d got %h at cyc %0d gap %0d required %h at cyc %0d gap 8",
                             i, got, tcyc, ncyc - last, exp, SLOT);
                end
            end
            last = ncyc;
            @(negedge clk);
        end
        goto_cyc(3);
        pulse_done(3'd5);
        checks++;
        if (sif.l2send_l2_ready !== 1'b1 || sif.l2send_l2_tag !== 3'd5) begin
            errors++;
            $display("FAIL fill_free5 got ready=%b tag=%0d required ready=1 tag=5",
                     sif.l2send_l2_ready, sif.l2send_l2_tag);
        end
        present(C_RDX, 26'h2AAAA);
        exp_q.push_back(mk(C_RDX, 3'd5, 26'h2AAAA));
        @(negedge clk);
        release_req();
        wait_issue(found);
        checks++;
        if (!found || exp_q.size() == 0) begin
            errors++;
            $display("FAIL fill_reuse got found=%0b queued=%0d required an issue", found, exp_q.size());
        end else begin
            exp = exp_q.pop_front();
            got = {sif.bus_req_cmd, sif.bus_req_tag, sif.bus_req_addr};
            if (got !== exp || tcyc !== SLOT) begin
                errors++;
                $display("FAIL fill_reuse got %h at cyc %0d required %h at cyc %0d", got, tcyc, exp, SLOT);
            end
        end
    endtask

    task automatic test_reset_inflight();
        do_reset();
        goto_cyc(3);
        present(C_RD, 26'h0F00D);
        exp_q.push_back(mk(C_RD, 3'd0, 26'h0F00D));
        @(negedge clk);
        release_req();
        wait_issue(found);
        checks++;
        if (!found || exp_q.size() == 0) begin
            errors++;
            $display("FAIL inflight_issue got found=%0b queued=%0d required an issue", found, exp_q.size());
        end else begin
            exp = exp_q.pop_front();
            got = {sif.bus_req_cmd, sif.bus_req_tag, sif.bus_req_addr};
            if (got !== exp || tcyc !== SLOT) begin
                errors++;
                $display("FAIL inflight_issue got %h at cyc %0d required %h at cyc %0d", got, tcyc, exp, SLOT);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        checks++;
        if (sif.bus_req_valid !== 1'b0 || sif.l2send_l2_ready !== 1'b1 || sif.l2send_l2_tag !== 3'd0) begin
            errors++;
            $display("FAIL inflight_reset got valid=%b ready=%b tag=%0d required 0/1/0",
                     sif.bus_req_valid, sif.l2send_l2_ready, sif.l2send_l2_tag);
        end
        sif.bus_nack = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (sif.bus_req_valid === 1'b1) found = 1'b1;
        end
        sif.bus_nack = 1'b0;
        pulse_done(3'd0);
        checks++;
        if (found || sif.l2send_l2_ready !== 1'b1 || sif.l2send_l2_tag !== 3'd0) begin
            errors++;
            $display("FAIL inflight_dropped got reissue=%0b ready=%b tag=%0d required 0/1/0",
                     found, sif.l2send_l2_ready, sif.l2send_l2_tag);
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_first_issue();
        test_nack_retry();
        test_addr_block();
        test_upgr();
        test_fill();
        test_reset_inflight();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
